// File: rtl/soc_addr_decoder_if.sv
// soc_addr_decoder_if
//   Bundles the three handshake channels of the address decoder.
//   req_* : incoming request (addr, id) from the initiator
//   fwd_* : decoded request with the selected slave index
//   err_* : unmapped (DECERR) request queue head
//   Modports: slave = decoder side, master = initiator/consumer side.
//   IdxWidth must equal $clog2(NumRules) of the attached decoder.
interface soc_addr_decoder_if #(
    parameter int AddrWidth = 64,
    parameter int IdWidth   = 4,
    parameter int IdxWidth  = 5
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_addr_i;
    logic [IdWidth-1:0]   req_id_i;

    logic                 fwd_valid_o;
    logic                 fwd_ready_i;
    logic [AddrWidth-1:0] fwd_addr_o;
    logic [IdWidth-1:0]   fwd_id_o;
    logic [IdxWidth-1:0]  fwd_idx_o;

    logic                 err_valid_o;
    logic                 err_ready_i;
    logic [AddrWidth-1:0] err_addr_o;
    logic [IdWidth-1:0]   err_id_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_id_i, fwd_ready_i, err_ready_i,
        output req_ready_o, fwd_valid_o, fwd_addr_o, fwd_id_o, fwd_idx_o,
               err_valid_o, err_addr_o, err_id_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_id_i, fwd_ready_i, err_ready_i,
        input  req_ready_o, fwd_valid_o, fwd_addr_o, fwd_id_o, fwd_idx_o,
               err_valid_o, err_addr_o, err_id_o
    );
endinterface

// File: rtl/soc_addr_decoder.sv
// soc_addr_decoder
//   Maps each request address onto one of NumRules [start, end) windows.
//   The lowest-index enabled hitting rule wins; mapped requests are
//   registered onto the fwd channel (1-cycle latency, 1 request/cycle),
//   unmapped ones are queued in an ErrDepth-entry FIFO and counted.
// Ports:
//   clk_i        : clock, rising edge
//   rst_ni       : synchronous active-low reset
//   rule_start_i : packed inclusive start addresses, rule i = slice i
//   rule_end_i   : packed exclusive end addresses, rule i = slice i
//   rule_en_i    : per-rule enable
//   bus          : req / fwd / err handshake channels (slave modport)
//   err_cnt_o    : saturating count of accepted unmapped requests
// NumRules must be at least 2; ErrDepth a power of two, at least 2.
module soc_addr_decoder #(
    parameter int NumRules  = 20,
    parameter int AddrWidth = 64,
    parameter int IdWidth   = 4,
    parameter int ErrDepth  = 4,
    localparam int IdxWidth = $clog2(NumRules)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumRules*AddrWidth-1:0] rule_start_i,
    input  logic [NumRules*AddrWidth-1:0] rule_end_i,
    input  logic [NumRules-1:0]           rule_en_i,
    soc_addr_decoder_if.slave             bus,
    output logic [15:0]                   err_cnt_o
);
    localparam int PtrWidth = $clog2(ErrDepth) + 1;

    logic                 hit;
    logic [IdxWidth-1:0]  hit_idx;

    logic                 fwd_valid;
    logic [AddrWidth-1:0] fwd_addr;
    logic [IdWidth-1:0]   fwd_id;
    logic [IdxWidth-1:0]  fwd_idx;

    logic [AddrWidth-1:0] fifo_addr [ErrDepth];
    logic [IdWidth-1:0]   fifo_id   [ErrDepth];
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic                 err_full;
    logic                 err_empty;

    logic                 accept;
    logic                 fwd_load;
    logic                 push;
    logic                 pop;
    logic [15:0]          err_cnt;

    // Priority decode: the first hit in ascending order is kept. A rule
    // with start >= end can never satisfy start <= addr < end.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NumRules; i++) begin
            if (!hit && rule_en_i[i] &&
                (rule_start_i[i*AddrWidth +: AddrWidth] <= bus.req_addr_i) &&
                (bus.req_addr_i < rule_end_i[i*AddrWidth +: AddrWidth])) begin
                hit     = 1'b1;
                hit_idx = IdxWidth'(i);
            end
        end
    end

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // low bits with differing wrap bits mean full.
    assign err_empty = (wr_ptr == rd_ptr);
    assign err_full  = (wr_ptr[PtrWidth-1] != rd_ptr[PtrWidth-1]) &&
                       (wr_ptr[PtrWidth-2:0] == rd_ptr[PtrWidth-2:0]);

    assign bus.req_ready_o = rst_ni && (!fwd_valid || bus.fwd_ready_i) && !err_full;
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign fwd_load        = accept && hit;
    assign push            = accept && !hit;
    assign pop             = !err_empty && bus.err_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_id    <= '0;
            fwd_idx   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            err_cnt   <= '0;
        end else begin
            if (fwd_load) begin
                fwd_valid <= 1'b1;
                fwd_addr  <= bus.req_addr_i;
                fwd_id    <= bus.req_id_i;
                fwd_idx   <= hit_idx;
            end else if (bus.fwd_ready_i) begin
                fwd_valid <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr[PtrWidth-2:0]] <= bus.req_addr_i;
            fifo_id[wr_ptr[PtrWidth-2:0]]   <= bus.req_id_i;
        end
    end

    assign bus.fwd_valid_o = fwd_valid;
    assign bus.fwd_addr_o  = fwd_addr;
    assign bus.fwd_id_o    = fwd_id;
    assign bus.fwd_idx_o   = fwd_idx;
    assign bus.err_valid_o = !err_empty;
    assign bus.err_addr_o  = fifo_addr[rd_ptr[PtrWidth-2:0]];
    assign bus.err_id_o    = fifo_id[rd_ptr[PtrWidth-2:0]];
    assign err_cnt_o       = err_cnt;
endmodule

// File: tb/tb_soc_addr_decoder.sv
`timescale 1ns/1ps
module tb_soc_addr_decoder;
    localparam int NR = 20;
    localparam int AW = 64;
    localparam int IW = 4;
    localparam int ED = 4;
    localparam int XW = $clog2(NR);

    logic clk = 1'b0;
    logic rst_n;
    logic [NR*AW-1:0] rule_start;
    logic [NR*AW-1:0] rule_end;
    logic [NR-1:0]    ren;
    logic [15:0]      err_cnt;
    logic [63:0]      rs [NR];
    logic [63:0]      re [NR];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    always #5 clk = ~clk;

    soc_addr_decoder_if #(.AddrWidth(AW), .IdWidth(IW), .IdxWidth(XW)) bus ();

    soc_addr_decoder #(.NumRules(NR), .AddrWidth(AW), .IdWidth(IW), .ErrDepth(ED)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rule_start_i (rule_start),
        .rule_end_i   (rule_end),
        .rule_en_i    (ren),
        .bus          (bus.slave),
        .err_cnt_o    (err_cnt)
    );

    always_comb begin
        rule_start = '0;
        rule_end   = '0;
        for (int i = 0; i < NR; i++) begin
            rule_start[i*AW +: AW] = rs[i];
            rule_end[i*AW +: AW]   = re[i];
        end
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference decode: straight from the rule definition on unpacked arrays.
    function automatic int ref_decode(logic [63:0] a);
        for (int i = 0; i < NR; i++)
            if (ren[i] && rs[i] <= a && a < re[i]) return i;
        return -1;
    endfunction

    task automatic setup_rules();
        for (int i = 0; i < NR; i++) begin
            rs[i] = 64'(i + 1) * 64'h1_0000_0000;
            re[i] = rs[i] + 64'h1_0000;
        end
        ren = '1;
        rs[0]  = 64'h0;                   re[0]  = 64'h1000;  ren[0] = 1'b0;
        rs[3]  = 64'h5000_0000;           re[3]  = 64'h5000_0000;
        rs[4]  = 64'h6000_1000;           re[4]  = 64'h6000_0000;
        rs[5]  = 64'h1C00_0000;           re[5]  = 64'h1D00_0000;
        rs[6]  = 64'h1800_0000;           re[6]  = 64'h2000_0000;
        rs[11] = 64'h4000_0000;           re[11] = 64'h4000_1000;
        rs[19] = 64'hFFFF_FFFF_FFFF_F000; re[19] = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    // Scoreboard: transactions held in queues, checked every cycle.
    typedef struct { logic [63:0] addr; logic [3:0] id; logic [4:0] idx; } txn_t;
    txn_t fq[$];
    txn_t eq[$];
    logic [15:0] m_cnt;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                check("mon_ready_in_reset", bus.req_ready_o, 0);
                fq.delete();
                eq.delete();
                m_cnt = '0;
            end else begin
                bit exp_ready;
                int d;
                txn_t t;
                check("mon_fwd_valid", bus.fwd_valid_o, fq.size() != 0);
                if (fq.size() != 0) begin
                    check("mon_fwd_addr", bus.fwd_addr_o, fq[0].addr);
                    check("mon_fwd_id", bus.fwd_id_o, fq[0].id);
                    check("mon_fwd_idx", bus.fwd_idx_o, fq[0].idx);
                end
                check("mon_err_valid", bus.err_valid_o, eq.size() != 0);
                if (eq.size() != 0) begin
                    check("mon_err_addr", bus.err_addr_o, eq[0].addr);
                    check("mon_err_id", bus.err_id_o, eq[0].id);
                end
                check("mon_err_cnt", err_cnt, m_cnt);
                exp_ready = (fq.size() == 0 || bus.fwd_ready_i) && eq.size() < ED;
                check("mon_req_ready", bus.req_ready_o, exp_ready);
                if (fq.size() != 0 && bus.fwd_ready_i) void'(fq.pop_front());
                if (eq.size() != 0 && bus.err_ready_i) void'(eq.pop_front());
                if (bus.req_valid_i && exp_ready) begin
                    d = ref_decode(bus.req_addr_i);
                    t.addr = bus.req_addr_i;
                    t.id   = bus.req_id_i;
                    t.idx  = (d < 0) ? 5'd0 : 5'(d);
                    if (d < 0) begin
                        eq.push_back(t);
                        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    end else begin
                        fq.push_back(t);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the request is taken.
    task automatic drive_req(input logic [63:0] a, input logic [3:0] id);
        int n = 0;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_id_i    = id;
        @(negedge clk);
        while (!bus.req_ready_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("drive_req_ready", bus.req_ready_o, 1);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct { logic [63:0] addr; logic [3:0] id; bit hit; logic [4:0] idx; } vec_t;
    vec_t vecs[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int misses;
        int acc;
        int cyc;
        logic [63:0] span;
        logic [63:0] a;
        int k;

        vecs[0]  = '{64'h4000_0FFC, 4'd3, 1'b1, 5'd11};
        vecs[1]  = '{64'h4000_1000, 4'd4, 1'b0, 5'd0};
        vecs[2]  = '{64'h4000_0000, 4'd5, 1'b1, 5'd11};
        vecs[3]  = '{64'h3FFF_FFFF, 4'd6, 1'b0, 5'd0};
        vecs[4]  = '{64'h1C00_0000, 4'd7, 1'b1, 5'd5};
        vecs[5]  = '{64'h1F00_0000, 4'd8, 1'b1, 5'd6};
        vecs[6]  = '{64'h5000_0000, 4'd9, 1'b0, 5'd0};
        vecs[7]  = '{64'h6000_0800, 4'd10, 1'b0, 5'd0};
        vecs[8]  = '{64'h0000_0100, 4'd11, 1'b0, 5'd0};
        vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFE, 4'd12, 1'b1, 5'd19};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd13, 1'b0, 5'd0};
        vecs[11] = '{64'h2_0000_0000, 4'd1, 1'b1, 5'd1};
        vecs[12] = '{64'h3_0000_FFFF, 4'd2, 1'b1, 5'd2};

        rst_n = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_id_i    = '0;
        bus.fwd_ready_i = 1'b0;
        bus.err_ready_i = 1'b0;
        setup_rules();
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_req_ready", bus.req_ready_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_fwd_valid", bus.fwd_valid_o, 0);
        check("reset_err_valid", bus.err_valid_o, 0);
        check("reset_fwd_addr", bus.fwd_addr_o, 0);
        check("reset_fwd_id", bus.fwd_id_o, 0);
        check("reset_fwd_idx", bus.fwd_idx_o, 0);
        check("reset_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;

        // Table-driven decode vectors
        bus.fwd_ready_i = 1'b1;
        bus.err_ready_i = 1'b1;
        misses = 0;
        for (int v = 0; v < 13; v++) begin
            drive_req(vecs[v].addr, vecs[v].id);
            @(negedge clk);
            if (vecs[v].hit) begin
                check("vec_fwd_valid", bus.fwd_valid_o, 1);
                check("vec_fwd_idx", bus.fwd_idx_o, vecs[v].idx);
                check("vec_fwd_id", bus.fwd_id_o, vecs[v].id);
                check("vec_fwd_addr", bus.fwd_addr_o, vecs[v].addr);
                check("vec_err_valid", bus.err_valid_o, 0);
            end else begin
                misses++;
                check("vec_err_valid", bus.err_valid_o, 1);
                check("vec_err_id", bus.err_id_o, vecs[v].id);
                check("vec_err_addr", bus.err_addr_o, vecs[v].addr);
                check("vec_fwd_valid", bus.fwd_valid_o, 0);
                check("vec_err_cnt", err_cnt, 64'(misses));
            end
            @(posedge clk);
            #1;
        end

        // Overlap with the lower rule disabled falls through to rule 6
        do_reset();
        ren[5] = 1'b0;
        drive_req(64'h1C00_0000, 4'd2);
        @(negedge clk);
        check("overlap_dis_idx", bus.fwd_idx_o, 6);
        @(posedge clk);
        #1;
        ren[5] = 1'b1;

        // Error FIFO fills with err_ready low, then drains in order
        do_reset();
        bus.err_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) drive_req(64'h4000_1000 + 64'(i), 4'(i));
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 64'h9000_0000;
        bus.req_id_i    = 4'd5;
        @(negedge clk);
        check("full_ready", bus.req_ready_o, 0);
        check("full_cnt", err_cnt, 4);
        check("full_head_id", bus.err_id_o, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("full_ready_hold", bus.req_ready_o, 0);
        @(posedge clk);
        #1;
        bus.err_ready_i = 1'b1;
        @(negedge clk);
        check("full_ready_popcycle", bus.req_ready_o, 0);
        @(posedge clk);
        #1;
        bus.err_ready_i = 1'b0;
        @(negedge clk);
        check("after_pop_ready", bus.req_ready_o, 1);
        check("after_pop_head", bus.err_id_o, 2);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("fifth_cnt", err_cnt, 5);
        @(posedge clk);
        #1;
        bus.err_ready_i = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            check("drain_valid", bus.err_valid_o, 1);
            check("drain_id", bus.err_id_o, i);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("drain_empty", bus.err_valid_o, 0);
        @(posedge clk);
        #1;

        // Stall with rule churn, then back-to-back forwarding
        do_reset();
        bus.fwd_ready_i = 1'b0;
        drive_req(64'h4000_0FFC, 4'd3);
        for (int i = 0; i < 3; i++) begin
            ren = ~ren;
            rs[11] = rs[11] + 64'h100;
            @(negedge clk);
            check("stall_valid", bus.fwd_valid_o, 1);
            check("stall_addr", bus.fwd_addr_o, 64'h4000_0FFC);
            check("stall_id", bus.fwd_id_o, 3);
            check("stall_idx", bus.fwd_idx_o, 11);
            check("stall_ready", bus.req_ready_o, 0);
            @(posedge clk);
            #1;
        end
        setup_rules();
        bus.fwd_ready_i = 1'b1;
        bus.req_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr_i = 64'h4000_0000 + 64'(i * 4);
            bus.req_id_i   = 4'(8 + i);
            @(negedge clk);
            check("b2b_ready", bus.req_ready_o, 1);
            check("b2b_valid", bus.fwd_valid_o, 1);
            check("b2b_id", bus.fwd_id_o, (i == 0) ? 3 : 8 + i - 1);
            @(posedge clk);
            #1;
        end
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("b2b_last_id", bus.fwd_id_o, 11);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b2b_idle", bus.fwd_valid_o, 0);
        @(posedge clk);
        #1;

        // Randomized traffic against the scoreboard
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            k = $urandom_range(0, NR - 1);
            case ($urandom_range(0, 5))
                0: begin
                    span = re[k] - rs[k];
                    a = (re[k] > rs[k]) ? rs[k] + ({$urandom, $urandom} % span) : rs[k];
                end
                1: a = rs[k] - 64'd1;
                2: a = re[k];
                3: a = re[k] - 64'd1;
                4: a = {$urandom, $urandom};
                default: a = rs[k];
            endcase
            bus.req_valid_i = ($urandom_range(0, 3) != 0);
            bus.req_addr_i  = a;
            bus.req_id_i    = 4'($urandom);
            bus.fwd_ready_i = ($urandom_range(0, 3) != 0);
            bus.err_ready_i = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 15) == 0) ren[$urandom_range(0, NR - 1)] ^= 1'b1;
            @(posedge clk);
            #1;
        end
        bus.req_valid_i = 1'b0;
        bus.fwd_ready_i = 1'b1;
        bus.err_ready_i = 1'b1;
        setup_rules();
        repeat (6) @(posedge clk);
        #1;

        // Counter saturation
        do_reset();
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 64'h4000_1000;
        bus.req_id_i    = '0;
        acc = 0;
        cyc = 0;
        while (acc < 65534 && cyc < 70000) begin
            @(negedge clk);
            if (bus.req_ready_o) acc++;
            cyc++;
            @(posedge clk);
            #1;
            bus.req_id_i = bus.req_id_i + 4'd1;
        end
        bus.req_valid_i = 1'b0;
        check("sat_preload_accepts", 64'(acc), 65534);
        @(negedge clk);
        check("sat_preload_cnt", err_cnt, 16'hFFFE);
        @(posedge clk);
        #1;
        drive_req(64'h4000_1000, 4'd1);
        drive_req(64'h4000_1004, 4'd2);
        @(negedge clk);
        check("sat_cnt_2", err_cnt, 16'hFFFF);
        @(posedge clk);
        #1;
        drive_req(64'h4000_1008, 4'd3);
        @(negedge clk);
        check("sat_cnt_3", err_cnt, 16'hFFFF);
        @(posedge clk);
        #1;

        // Reset mid-operation discards held and queued requests
        bus.fwd_ready_i = 1'b0;
        bus.err_ready_i = 1'b0;
        drive_req(64'h4000_1000, 4'd1);
        drive_req(64'h4000_1004, 4'd2);
        drive_req(64'h4000_0010, 4'd3);
        @(negedge clk);
        check("pre_rst_fwd_valid", bus.fwd_valid_o, 1);
        check("pre_rst_err_valid", bus.err_valid_o, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.req_ready_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_fwd_valid", bus.fwd_valid_o, 0);
        check("post_rst_err_valid", bus.err_valid_o, 0);
        check("post_rst_err_cnt", err_cnt, 0);
        check("post_rst_fwd_idx", bus.fwd_idx_o, 0);
        bus.fwd_ready_i = 1'b1;
        bus.err_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_fwd", bus.fwd_valid_o, 0);
            check("post_rst_no_err", bus.err_valid_o, 0);
        end

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/soc_addr_decoder.md
SOC_ADDR_DECODER -- requirements
Module: soc_addr_decoder

Interface
REQ-001 SHALL have parameter NumRules, default 20, meaning the number of address rules (one per crossbar slave index).
REQ-002 SHALL have parameter AddrWidth, default 64, meaning the request address width.
REQ-003 SHALL have parameter IdWidth, default 4, meaning the transaction ID width.
REQ-004 SHALL have parameter ErrDepth, default 4, meaning the error-FIFO depth (power of two, at least 2).
REQ-005 SHALL have port clk_i  in  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port rule_start_i  in  NumRules*AddrWidth  inclusive start address of each rule; rule i is slice i.
REQ-008 SHALL have port rule_end_i  in  NumRules*AddrWidth  exclusive end address of each rule; rule i is slice i.
REQ-009 SHALL have port rule_en_i  in  NumRules  per-rule enable.
REQ-010 SHALL have ports req_valid_i in 1, req_ready_o out 1, req_addr_i in AddrWidth, req_id_i in IdWidth: the request channel.
REQ-011 SHALL have ports fwd_valid_o out 1, fwd_ready_i in 1, fwd_addr_o out AddrWidth, fwd_id_o out IdWidth, fwd_idx_o out $clog2(NumRules): the decoded request.
REQ-012 SHALL have ports err_valid_o out 1, err_ready_i in 1, err_addr_o out AddrWidth, err_id_o out IdWidth: the unmapped-request (DECERR) channel.
REQ-013 SHALL have port err_cnt_o  out  16  count of unmapped requests accepted.

Function
REQ-014 SHALL treat rule i as a hit when rule_en_i[i]=1 and start_i <= addr < end_i, using unsigned AddrWidth-bit compares.
REQ-015 SHALL treat a rule with start >= end as never hitting.
REQ-016 SHALL select the lowest-index hitting rule when several rules hit.
REQ-017 SHALL classify a request as unmapped when no rule hits.
REQ-018 SHALL accept a request on a cycle with req_valid_i=1 and req_ready_o=1.
REQ-019 SHALL drive req_ready_o = (!fwd_valid_o | fwd_ready_i) & !err_full, where err_full means the FIFO holds ErrDepth entries.
REQ-020 SHALL decode a mapped request in the acceptance cycle and register addr, id and idx into the fwd outputs, with fwd_valid_o=1 on the next cycle (latency 1).
REQ-021 SHALL hold the fwd outputs stable while fwd_valid_o=1 and fwd_ready_i=0, independent of any change on the rule inputs.
REQ-022 SHALL clear fwd_valid_o after a fwd handshake unless a new mapped request is accepted in the same cycle, in which case the register reloads back-to-back (1 request/cycle).
REQ-023 SHALL push an unmapped request (addr, id) into the error FIFO; the entry is visible on err_* no earlier than the next cycle.
REQ-024 SHALL present the FIFO head on err_*, pop it on err_valid_o & err_ready_i, and preserve arrival order.
REQ-025 SHALL allow a push and a pop in the same cycle when the FIFO is neither empty nor full, leaving the occupancy unchanged; no push occurs while full.
REQ-026 SHALL use wrapping read and write pointers of $clog2(ErrDepth)+1 bits to distinguish full from empty.
REQ-027 SHALL increment err_cnt_o by 1 for each unmapped request accepted, saturating at 16'hFFFF.
REQ-028 SHALL never present a single request on both fwd_* and err_*.

Reset
REQ-029 SHALL, with rst_ni=0 sampled on a clock edge, set fwd_valid_o=0, err_valid_o=0, fwd_addr_o/fwd_id_o/fwd_idx_o=0, the FIFO empty, and err_cnt_o=0.
REQ-030 SHALL discard any held or queued request on reset mid-operation, with no output handshake for it afterwards.
REQ-031 SHALL drive req_ready_o=0 while rst_ni=0.

Verification
REQ-032 SHALL cover: rule 11 = [0x4000_0000, 0x4000_1000), req addr 0x4000_0FFC id 3 -> next cycle fwd_valid_o=1, idx 11, id 3; addr 0x4000_1000 -> err_valid_o=1, err_cnt_o=1.
REQ-033 SHALL cover: rules 5 and 6 both covering 0x1C00_0000 -> fwd_idx_o=5; rule 5 disabled -> fwd_idx_o=6.
REQ-034 SHALL cover: err_ready_i=0 with 5 unmapped requests -> 4 accepted, req_ready_o=0 on the 5th; one pop -> the 5th is accepted; the pops then return ids in order.
REQ-035 SHALL cover: fwd_ready_i=0 for 3 cycles with rule inputs toggled -> fwd outputs unchanged; fwd_ready_i=1 with req_valid_i held -> back-to-back transfers, one per cycle.
REQ-036 SHALL cover: err_cnt_o preloaded to 16'hFFFE by driving unmapped traffic, then 3 more unmapped requests -> err_cnt_o=16'hFFFF.
REQ-037 SHALL cover: rst_ni=0 for one cycle while fwd_valid_o=1 and 2 FIFO entries are queued -> next cycle fwd_valid_o=0, err_valid_o=0, err_cnt_o=0.
